imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator with a small output FIFO.
// Each accepted instruction is decoded in the same cycle: format,
// sign-extended immediate, branch/jump/AUIPC target and an illegal flag.
// The results are queued in a DEPTH-entry buffer. The head entry is
// presented with a valid/ready handshake. flush empties the buffer
// synchronously, and rst_n empties it asynchronously.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              inst,
    input  logic [XLEN-1:0]          pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          imm,
    output logic [2:0]               fmt,
    output logic [XLEN-1:0]          target,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_U = 3'b010;
    localparam logic [2:0] FMT_J = 3'b011;
    localparam logic [2:0] FMT_B = 3'b100;
    localparam logic [2:0] FMT_R = 3'b101;
    localparam logic [2:0] FMT_X = 3'b111;

    // Every immediate fits in 32 bits after sign extension. Each one is built
    // at 32 bits here and then widened to XLEN in a single place.
    logic [31:0]      w_imm_i;
    logic [31:0]      w_imm_s;
    logic [31:0]      w_imm_b;
    logic [31:0]      w_imm_j;
    logic [31:0]      w_imm_u;
    logic [31:0]      w_imm32;
    logic [2:0]       w_fmt;
    logic             w_ill;
    logic             w_use_tgt;
    logic [XLEN-1:0]  w_imm;
    logic [XLEN-1:0]  w_target;

    assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign w_imm_u = {inst[31:12], 12'b0};

    // Opcode decode: select the format, the immediate and whether a target is formed.
    always_comb begin
        w_fmt     = FMT_X;
        w_ill     = 1'b1;
        w_imm32   = 32'd0;
        w_use_tgt = 1'b0;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                w_fmt   = FMT_I;
                w_ill   = 1'b0;
                w_imm32 = w_imm_i;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    w_fmt   = FMT_I;
                    w_ill   = 1'b0;
                    w_imm32 = w_imm_i;
                end else begin
                    w_fmt   = FMT_X;
                    w_ill   = 1'b1;
                    w_imm32 = 32'd0;
                end
            end
            7'b0100011: begin
                w_fmt   = FMT_S;
                w_ill   = 1'b0;
                w_imm32 = w_imm_s;
            end
            7'b1100011: begin
                w_fmt     = FMT_B;
                w_ill     = 1'b0;
                w_imm32   = w_imm_b;
                w_use_tgt = 1'b1;
            end
            7'b0110111: begin
                w_fmt   = FMT_U;
                w_ill   = 1'b0;
                w_imm32 = w_imm_u;
            end
            7'b0010111: begin
                // AUIPC is the only U-type opcode that produces a pc-relative target.
                w_fmt     = FMT_U;
                w_ill     = 1'b0;
                w_imm32   = w_imm_u;
                w_use_tgt = 1'b1;
            end
            7'b1101111: begin
                w_fmt     = FMT_J;
                w_ill     = 1'b0;
                w_imm32   = w_imm_j;
                w_use_tgt = 1'b1;
            end
            7'b0110011: begin
                w_fmt   = FMT_R;
                w_ill   = 1'b0;
                w_imm32 = 32'd0;
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    w_fmt   = FMT_R;
                    w_ill   = 1'b0;
                    w_imm32 = 32'd0;
                end else begin
                    w_fmt   = FMT_X;
                    w_ill   = 1'b1;
                    w_imm32 = 32'd0;
                end
            end
            default: begin
                w_fmt     = FMT_X;
                w_ill     = 1'b1;
                w_imm32   = 32'd0;
                w_use_tgt = 1'b0;
            end
        endcase
    end

    // Sign-extend the 32-bit immediate to the datapath width.
    generate
        if (XLEN == 64) begin : g_ext64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_ext32
            assign w_imm = w_imm32;
        end
    endgenerate

    // The add wraps modulo 2^XLEN. No carry is kept.
    assign w_target = w_use_tgt ? (pc + w_imm) : {XLEN{1'b0}};

    // Buffer storage and control state.
    logic [XLEN-1:0]   r_imm_mem [DEPTH];
    logic [2:0]        r_fmt_mem [DEPTH];
    logic [XLEN-1:0]   r_tgt_mem [DEPTH];
    logic              r_ill_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // in_ready depends only on occupancy, flush and reset, never on out_ready.
    // A slot freed by a pop therefore becomes usable one cycle later.
    assign in_ready  = rst_n && !flush && (r_count < DEPTH_C);
    assign out_valid = (r_count != {CNT_W{1'b0}});
    assign count     = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;

    // Write decoded fields into the tail slot. Slot contents do not need a
    // reset because they are masked while out_valid is low.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm_mem[r_wr_ptr] <= w_imm;
            r_fmt_mem[r_wr_ptr] <= w_fmt;
            r_tgt_mem[r_wr_ptr] <= w_target;
            r_ill_mem[r_wr_ptr] <= w_ill;
        end
    end

    // Pointer and occupancy update. Reset and flush both empty the buffer,
    // and flush takes priority over a push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Present the head entry. All fields are forced to zero while the buffer is empty.
    always_comb begin
        if (out_valid) begin
            imm     = r_imm_mem[r_rd_ptr];
            fmt     = r_fmt_mem[r_rd_ptr];
            target  = r_tgt_mem[r_rd_ptr];
            illegal = r_ill_mem[r_rd_ptr];
        end else begin
            imm     = {XLEN{1'b0}};
            fmt     = 3'b000;
            target  = {XLEN{1'b0}};
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. It instantiates one XLEN=32 copy and one
// XLEN=64 copy. Directed vectors carry hand-computed expectations. Each
// expectation is queued when the DUT accepts the vector, and a per-instance
// monitor compares the head entry on every cycle that the DUT presents one.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // XLEN=32 instance signals
    logic        flush, in_valid, out_ready, in_ready, out_valid, illegal;
    logic [31:0] inst, pc, imm, target;
    logic [2:0]  fmt;
    logic [1:0]  count;

    // XLEN=64 instance signals
    logic        flush64, in_valid64, out_ready64, in_ready64, out_valid64, illegal64;
    logic [31:0] inst64;
    logic [63:0] pc64, imm64, target64;
    logic [2:0]  fmt64;
    logic [1:0]  count64;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .inst(inst), .pc(pc), .out_valid(out_valid),
        .out_ready(out_ready), .imm(imm), .fmt(fmt), .target(target),
        .illegal(illegal), .count(count)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .in_valid(in_valid64),
        .in_ready(in_ready64), .inst(inst64), .pc(pc64), .out_valid(out_valid64),
        .out_ready(out_ready64), .imm(imm64), .fmt(fmt64), .target(target64),
        .illegal(illegal64), .count(count64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] target;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t cur32;
    exp_t cur64;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Record an expectation for every accepted vector (handshake seen before the edge).
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) q32.push_back(cur32);
        if (rst_n && in_valid64 && in_ready64) q64.push_back(cur64);
    end

    // Monitor for the XLEN=32 instance: compare the head entry each cycle and pop on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q32.size() == 0) begin
                    chk("out32_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    chk("imm32",    64'(imm),     q32[0].imm);
                    chk("fmt32",    64'(fmt),     64'(q32[0].fmt));
                    chk("target32", 64'(target),  q32[0].target);
                    chk("illegal32", 64'(illegal), 64'(q32[0].ill));
                end
            end else begin
                chk("idle32_zero", 64'(imm) | 64'(target) | 64'(fmt) | 64'(illegal), 64'd0);
            end
            if (flush) q32.delete();
            else if (out_valid && out_ready && q32.size() != 0) void'(q32.pop_front());
        end
    end

    // Monitor for the XLEN=64 instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid64) begin
                if (q64.size() == 0) begin
                    chk("out64_unexpected", 64'(out_valid64), 64'd0);
                end else begin
                    chk("imm64",     imm64,          q64[0].imm);
                    chk("fmt64",     64'(fmt64),     64'(q64[0].fmt));
                    chk("target64",  target64,       q64[0].target);
                    chk("illegal64", 64'(illegal64), 64'(q64[0].ill));
                end
            end
            if (flush64) q64.delete();
            else if (out_valid64 && out_ready64 && q64.size() != 0) void'(q64.pop_front());
        end
    end

    task automatic drive32(input logic [31:0] i, input logic [31:0] p, input logic [31:0] e_imm,
                           input logic [2:0] e_fmt, input logic [31:0] e_tgt, input logic e_ill);
        inst         = i;
        pc           = p;
        cur32.imm    = {32'd0, e_imm};
        cur32.fmt    = e_fmt;
        cur32.target = {32'd0, e_tgt};
        cur32.ill    = e_ill;
        in_valid     = 1'b1;
    endtask

    task automatic wait_acc32();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept32_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] i, input logic [31:0] p, input logic [31:0] e_imm,
                          input logic [2:0] e_fmt, input logic [31:0] e_tgt, input logic e_ill);
        drive32(i, p, e_imm, e_fmt, e_tgt, e_ill);
        wait_acc32();
    endtask

    task automatic send64(input logic [31:0] i, input logic [63:0] p, input logic [63:0] e_imm,
                          input logic [2:0] e_fmt, input logic [63:0] e_tgt, input logic e_ill);
        logic done;
        inst64       = i;
        pc64         = p;
        cur64.imm    = e_imm;
        cur64.fmt    = e_fmt;
        cur64.target = e_tgt;
        cur64.ill    = e_ill;
        in_valid64   = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready64) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept64_timeout", 64'd0, 64'd1);
        in_valid64 = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && (q32.size() != 0 || q64.size() != 0); k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inst = 32'd0; pc = 32'd0;
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b1; inst64 = 32'd0; pc64 = 64'd0;
        cur32 = '0; cur64 = '0;

        // Reset state
        #3;
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_fields",    64'(imm) | 64'(target) | 64'(fmt) | 64'(illegal), 64'd0);
        chk("rst_in_ready64", 64'(in_ready64), 64'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // XLEN=32 decode vectors, streamed with out_ready held high
        send32(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 3'b000, 32'h0000_0000, 1'b0);
        send32(32'h0080006F, 32'h0000_1000, 32'h0000_0008, 3'b011, 32'h0000_1008, 1'b0);
        send32(32'hFE000EE3, 32'h0000_2000, 32'hFFFF_FFFC, 3'b100, 32'h0000_1FFC, 1'b0);
        send32(32'hFE20AC23, 32'h0000_0040, 32'hFFFF_FFF8, 3'b001, 32'h0000_0000, 1'b0);
        send32(32'h123452B7, 32'h0000_0040, 32'h1234_5000, 3'b010, 32'h0000_0000, 1'b0);
        send32(32'h00001097, 32'h0000_0100, 32'h0000_1000, 3'b010, 32'h0000_1100, 1'b0);
        send32(32'hFFFFF117, 32'h0000_3000, 32'hFFFF_F000, 3'b010, 32'h0000_2000, 1'b0);
        send32(32'h002081B3, 32'h0000_0100, 32'h0000_0000, 3'b101, 32'h0000_0000, 1'b0);
        send32(32'h0000001B, 32'h0000_0100, 32'h0000_0000, 3'b111, 32'h0000_0000, 1'b1);
        send32(32'h0000003B, 32'h0000_0100, 32'h0000_0000, 3'b111, 32'h0000_0000, 1'b1);
        send32(32'hFFF00090, 32'h0000_0100, 32'h0000_0000, 3'b111, 32'h0000_0000, 1'b1);
        send32(32'hFFDFF06F, 32'h0000_0000, 32'hFFFF_FFFC, 3'b011, 32'hFFFF_FFFC, 1'b0);
        send32(32'h80002003, 32'h0000_0500, 32'hFFFF_F800, 3'b000, 32'h0000_0000, 1'b0);
        send32(32'h7FF080E7, 32'h0000_0500, 32'h0000_07FF, 3'b000, 32'h0000_0000, 1'b0);
        send32(32'h00000073, 32'h0000_0500, 32'h0000_0000, 3'b000, 32'h0000_0000, 1'b0);
        drain();

        // XLEN=64 decode vectors
        send64(32'h123452B7, 64'h0, 64'h0000_0000_1234_5000, 3'b010, 64'h0, 1'b0);
        send64(32'hFE20AC23, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 3'b001, 64'h0, 1'b0);
        send64(32'hFFF0809B, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 64'h0, 1'b0);
        send64(32'h002081BB, 64'h0, 64'h0, 3'b101, 64'h0, 1'b0);
        send64(32'h800000B7, 64'h0, 64'hFFFF_FFFF_8000_0000, 3'b010, 64'h0, 1'b0);
        send64(32'hFFFFF097, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_F000, 3'b010,
               64'h0000_0000_FFFF_F000, 1'b0);
        send64(32'hFE000EE3, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 3'b100, 64'h1FFC, 1'b0);
        drain();

        // Full buffer: the third entry waits upstream, then all three drain in order
        out_ready = 1'b0;
        send32(32'h00100093, 32'h0, 32'h0000_0001, 3'b000, 32'h0, 1'b0);
        send32(32'h00200093, 32'h0, 32'h0000_0002, 3'b000, 32'h0, 1'b0);
        drive32(32'h00300093, 32'h0, 32'h0000_0003, 3'b000, 32'h0, 1'b0);
        @(negedge clk);
        chk("full_count",    64'(count),    64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        chk("full_in_ready_oready", 64'(in_ready), 64'd0);
        chk("full_count_held",      64'(count),    64'd2);
        wait_acc32();
        drain();

        // Flush with two entries buffered and an entry offered at the same time
        out_ready = 1'b0;
        send32(32'h00400093, 32'h0, 32'h0000_0004, 3'b000, 32'h0, 1'b0);
        send32(32'h00500093, 32'h0, 32'h0000_0005, 3'b000, 32'h0, 1'b0);
        flush = 1'b1;
        drive32(32'h00600093, 32'h0, 32'h0000_0006, 3'b000, 32'h0, 1'b0);
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count",     64'(count),     64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send32(32'h00000000, 32'h0, 32'h0, 3'b111, 32'h0, 1'b1);
        drain();

        // Asynchronous reset mid-stream with two entries buffered
        out_ready = 1'b0;
        send32(32'h00700093, 32'h0, 32'h0000_0007, 3'b000, 32'h0, 1'b0);
        send32(32'h00800093, 32'h0, 32'h0000_0008, 3'b000, 32'h0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        q32.delete();
        q64.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count",     64'(count),     64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send32(32'h00900093, 32'h0, 32'h0000_0009, 3'b000, 32'h0, 1'b0);
        drain();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
